// File: rtl/fp_cond_unit.sv
// fp_cond_unit: c.cond.s evaluation into FCC bits with a two-stage accept/commit pipeline.
// Define FP_COND_FORWARD_EN to bypass the pending result to branch queries instead of stalling.
module fp_cond_unit #(
  parameter int NUM_CC = 8,
  parameter logic [NUM_CC-1:0] RESET_FCC = '0,
  localparam int CW = $clog2(NUM_CC)
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic [3:0]        req_cond,
  input  logic [CW-1:0]     req_cc,
  input  logic              cmp_lt,
  input  logic              cmp_eq,
  input  logic              cmp_gt,
  input  logic              cmp_snan,
  input  logic              fcc_wr_en,
  input  logic [NUM_CC-1:0] fcc_wr_data,
  input  logic [CW-1:0]     br_cc,
  output logic              br_value,
  output logic              br_stall,
  output logic [NUM_CC-1:0] fcc,
  output logic              invalid_flag,
  input  logic              invalid_clr
);
  logic              unordered, result, invalid_evt, accept, hit;
  logic              pend_valid, pend_result, pend_inv;
  logic [CW-1:0]     pend_cc;
  logic [NUM_CC-1:0] fcc_nxt;
  assign unordered   = ~(cmp_lt | cmp_eq | cmp_gt);
  assign result      = (req_cond[2] & cmp_lt) | (req_cond[1] & cmp_eq) | (req_cond[0] & unordered);
  assign invalid_evt = cmp_snan | (req_cond[3] & unordered);
  assign req_ready   = ~fcc_wr_en;
  assign accept      = req_valid & req_ready;
  assign hit         = pend_valid & (pend_cc == br_cc);
  // a committing compare overrides the bulk value for its own bit
  always_comb begin
    fcc_nxt = fcc_wr_en ? fcc_wr_data : fcc;
    if (pend_valid) fcc_nxt[pend_cc] = pend_result;
  end
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      fcc          <= RESET_FCC;
      invalid_flag <= 1'b0;
      pend_valid   <= 1'b0;
      pend_cc      <= '0;
      pend_result  <= 1'b0;
      pend_inv     <= 1'b0;
    end else begin
      fcc          <= fcc_nxt;
      invalid_flag <= (pend_valid & pend_inv) | (invalid_flag & ~invalid_clr);
      pend_valid   <= accept;
      if (accept) begin
        pend_cc     <= req_cc;
        pend_result <= result;
        pend_inv    <= invalid_evt;
      end
    end
  end
`ifdef FP_COND_FORWARD_EN
  assign br_value = hit ? pend_result : fcc[br_cc];
  assign br_stall = 1'b0;
`else
  assign br_value = fcc[br_cc];
  assign br_stall = hit;
`endif
endmodule

// File: tb/tb_fp_cond_unit.sv
// tb_fp_cond_unit: directed vectors for fp_cond_unit with hand-computed expectations.
module tb_fp_cond_unit;
  logic       clk = 0, reset = 1;
  logic       req_valid = 0, req_ready;
  logic [3:0] req_cond = 0;
  logic [2:0] req_cc = 0, br_cc = 0;
  logic       cmp_lt = 0, cmp_eq = 0, cmp_gt = 0, cmp_snan = 0;
  logic       fcc_wr_en = 0, invalid_clr = 0;
  logic [7:0] fcc_wr_data = 0, fcc;
  logic       br_value, br_stall, invalid_flag;
  int         n_run = 0, n_fail = 0;

  fp_cond_unit dut (
    .clk(clk), .reset(reset), .req_valid(req_valid), .req_ready(req_ready),
    .req_cond(req_cond), .req_cc(req_cc), .cmp_lt(cmp_lt), .cmp_eq(cmp_eq),
    .cmp_gt(cmp_gt), .cmp_snan(cmp_snan), .fcc_wr_en(fcc_wr_en),
    .fcc_wr_data(fcc_wr_data), .br_cc(br_cc), .br_value(br_value),
    .br_stall(br_stall), .fcc(fcc), .invalid_flag(invalid_flag),
    .invalid_clr(invalid_clr)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [7:0] got, input logic [7:0] exp);
    n_run++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%02h expected 0x%02h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic req(input logic [3:0] c, input logic [2:0] cc, input logic lt, eq, gt, sn);
    req_valid = 1; req_cond = c; req_cc = cc;
    cmp_lt = lt; cmp_eq = eq; cmp_gt = gt; cmp_snan = sn;
  endtask

  task automatic idle();
    req_valid = 0; cmp_lt = 0; cmp_eq = 0; cmp_gt = 0; cmp_snan = 0;
  endtask

  initial begin
    step(); step();
    check("rst_fcc", fcc, 8'h00);
    check("rst_inv", {7'b0, invalid_flag}, 8'h00);
    check("rst_ready", {7'b0, req_ready}, 8'h01);
    check("rst_stall", {7'b0, br_stall}, 8'h00);
    reset = 0;
    step();
    // c.eq to cc3
    req(4'h2, 3'd3, 0, 1, 0, 0);
    step(); idle();
    check("ceq_1edge", fcc, 8'h00);
    step();
    check("ceq_commit", fcc, 8'h08);
    check("ceq_inv", {7'b0, invalid_flag}, 8'h00);
    // back-to-back c.olt / c.ult to cc0
    req(4'h4, 3'd0, 1, 0, 0, 0); #1;
    check("b2b_ready0", {7'b0, req_ready}, 8'h01);
    step();
    req(4'h5, 3'd0, 0, 0, 0, 0); #1;
    check("b2b_ready1", {7'b0, req_ready}, 8'h01);
    step(); idle();
    check("olt_commit", fcc, 8'h09);
    step();
    check("ult_commit", fcc, 8'h09);
    // later request to the same cc wins
    req(4'h2, 3'd1, 0, 1, 0, 0); step();
    req(4'h4, 3'd1, 0, 1, 0, 0); step(); idle();
    check("same_cc_first", fcc, 8'h0B);
    step();
    check("same_cc_last", fcc, 8'h09);
    // bulk write
    fcc_wr_en = 1; fcc_wr_data = 8'hFF; #1;
    check("bulk_ready", {7'b0, req_ready}, 8'h00);
    step(); fcc_wr_en = 0;
    check("bulk_fcc", fcc, 8'hFF);
    // c.seq unordered -> result 0, invalid
    req(4'hA, 3'd5, 0, 0, 0, 0); step(); idle(); step();
    check("cseq_fcc", fcc, 8'hDF);
    check("cseq_inv", {7'b0, invalid_flag}, 8'h01);
    invalid_clr = 1; step(); invalid_clr = 0;
    check("inv_clr", {7'b0, invalid_flag}, 8'h00);
    // snan commit coincides with clear: set wins
    req(4'h2, 3'd6, 0, 1, 0, 1); step(); idle();
    invalid_clr = 1; step(); invalid_clr = 0;
    check("inv_set_wins", {7'b0, invalid_flag}, 8'h01);
    step();
    check("inv_sticky", {7'b0, invalid_flag}, 8'h01);
    invalid_clr = 1; step(); invalid_clr = 0;
    // commit beats bulk write on its own bit
    req(4'h4, 3'd2, 1, 0, 0, 0); step(); idle();
    fcc_wr_en = 1; fcc_wr_data = 8'h00; #1;
    check("bulk_commit_ready", {7'b0, req_ready}, 8'h00);
    step(); fcc_wr_en = 0;
    check("bulk_commit_fcc", fcc, 8'h04);
    // request blocked during bulk write never commits
    fcc_wr_en = 1; fcc_wr_data = 8'h00; req(4'h2, 3'd7, 0, 1, 0, 0);
    step(); fcc_wr_en = 0; idle(); step();
    check("blocked_req", fcc, 8'h00);
    // branch on pending cc2
    br_cc = 3'd2;
    req(4'h4, 3'd2, 1, 0, 0, 0); step(); idle(); #1;
`ifdef FP_COND_FORWARD_EN
    check("br_fwd_stall", {7'b0, br_stall}, 8'h00);
    check("br_fwd_value", {7'b0, br_value}, 8'h01);
`else
    check("br_stall", {7'b0, br_stall}, 8'h01);
    check("br_arch_value", {7'b0, br_value}, 8'h00);
`endif
    br_cc = 3'd3; #1;
    check("br_other_stall", {7'b0, br_stall}, 8'h00);
    br_cc = 3'd2;
    step();
    check("br_after_stall", {7'b0, br_stall}, 8'h00);
    check("br_after_value", {7'b0, br_value}, 8'h01);
    // reset mid-pipeline discards the pending request
    br_cc = 3'd4;
    req(4'h2, 3'd4, 0, 1, 0, 0); step(); idle();
    #2 reset = 1; #1;
    check("midrst_fcc", fcc, 8'h00);
    check("midrst_stall", {7'b0, br_stall}, 8'h00);
    check("midrst_value", {7'b0, br_value}, 8'h00);
    @(posedge clk); #1 reset = 0;
    step(); step();
    check("midrst_nocommit", fcc, 8'h00);
    $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
    $finish;
  end
endmodule
